// File: rtl/booth_pkg.sv
// -----------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the arithmetic controllers (restoring divider and the
// multiplier controller).
//   - DEFAULT_DATA_WIDTH : default operand/result width in bits
//   - div_state_e        : divider FSM encoding (IDLE=0, RUN=1, DONE=2)
//   - cnt_width()        : width needed to hold an iteration count 0..w
// -----------------------------------------------------------------------------
package booth_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Number of bits required to represent the values 0..w inclusive.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage : booth_pkg

// File: rtl/restoring_divider_if.sv
// -----------------------------------------------------------------------------
// restoring_divider_if
// Request/result bundle between a divider client (master) and the divider
// (slave).
//   start       master->slave  request a division (honoured only while idle)
//   dividend    master->slave  unsigned numerator, captured with start
//   divisor     master->slave  unsigned denominator, captured with start
//   busy        slave->master  high while an operation is in flight
//   done        slave->master  one-cycle completion pulse
//   quotient    slave->master  result quotient (held until next result)
//   remainder   slave->master  result remainder (held until next result)
//   div_by_zero slave->master  qualifies the last result, valid with done
//
// Handshake: start is a request, not a valid/ready pair. It is accepted on a
// rising edge only when busy is low; while busy is high start and the operand
// buses are ignored. Each accepted request produces exactly one done pulse
// (unless aborted by clear); results are valid in the done cycle and stay
// stable afterwards until the next done.
// -----------------------------------------------------------------------------
interface restoring_divider_if #(
    parameter int DATA_WIDTH = booth_pkg::DEFAULT_DATA_WIDTH
);

    logic                  start;
    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] quotient;
    logic [DATA_WIDTH-1:0] remainder;
    logic                  div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface : restoring_divider_if

// File: rtl/restoring_divider_restore_step.sv
// -----------------------------------------------------------------------------
// restore_step
// One combinational iteration of restoring division: shift {A,Q} left by one,
// trial-subtract the divisor from A, and either keep the difference (quotient
// bit 1) or restore the shifted A (quotient bit 0).
//   a_i  [DATA_WIDTH:0]   partial remainder A
//   q_i  [DATA_WIDTH-1:0] dividend/quotient shift register Q
//   m_i  [DATA_WIDTH-1:0] divisor M
//   a_o  [DATA_WIDTH:0]   next A
//   q_o  [DATA_WIDTH-1:0] next Q
// -----------------------------------------------------------------------------
module restore_step #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH:0]   a_i,
    input  logic [DATA_WIDTH-1:0] q_i,
    input  logic [DATA_WIDTH-1:0] m_i,
    output logic [DATA_WIDTH:0]   a_o,
    output logic [DATA_WIDTH-1:0] q_o
);

    logic [DATA_WIDTH:0]   a_sh;
    logic [DATA_WIDTH-1:0] q_sh;
    logic [DATA_WIDTH:0]   trial;
    // A < M holds between steps, so A's MSB is always zero and the left shift
    // never loses information; the bit is carried only to keep A's width.
    logic                  unused_a_msb;

    always_comb begin
        unused_a_msb = a_i[DATA_WIDTH];
        a_sh         = {a_i[DATA_WIDTH-1:0], q_i[DATA_WIDTH-1]};
        q_sh         = {q_i[DATA_WIDTH-2:0], 1'b0};
        trial        = a_sh - {1'b0, m_i};
        a_o          = a_sh;
        q_o          = q_sh;
        // MSB of the trial difference is the sign: 0 means A >= M.
        if (!trial[DATA_WIDTH]) begin
            a_o = trial;
            q_o = {q_sh[DATA_WIDTH-1:1], 1'b1};
        end
    end

endmodule : restore_step

// File: rtl/restoring_divider.sv
// -----------------------------------------------------------------------------
// restoring_divider
// Iterative unsigned restoring divider, one quotient bit per clock.
//   clk      rising-edge clock
//   clear    synchronous active-low reset; aborts any operation in flight
//   div_if   slave side of restoring_divider_if (start/operands in,
//            busy/done/quotient/remainder/div_by_zero out)
//   state_o  current FSM state, for observation only
//
// Timing: a start sampled at edge E loads the operands and enters RUN; the
// DATA_WIDTH RUN cycles end at edge E+DATA_WIDTH, which writes the results
// and enters DONE, so done is high in the cycle after that edge. A zero
// divisor skips RUN: edge E writes the saturated result and enters DONE.
// DONE always falls back to IDLE on the next edge, so a new start can be
// presented in the cycle right after done.
// -----------------------------------------------------------------------------
module restoring_divider
    import booth_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                clk,
    input  logic                clear,
    restoring_divider_if.slave  div_if,
    output div_state_e          state_o
);

    localparam int CW = cnt_width(DATA_WIDTH);

    div_state_e            state_q;
    logic [DATA_WIDTH:0]   a_q;
    logic [DATA_WIDTH-1:0] q_q;
    logic [DATA_WIDTH-1:0] m_q;
    logic [CW-1:0]         count_q;
    logic [DATA_WIDTH-1:0] quot_q;
    logic [DATA_WIDTH-1:0] rem_q;
    logic                  dbz_q;
    logic                  done_q;

    logic [DATA_WIDTH:0]   a_d;
    logic [DATA_WIDTH-1:0] q_d;

    restore_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .a_i (a_q),
        .q_i (q_q),
        .m_i (m_q),
        .a_o (a_d),
        .q_o (q_d)
    );

    always_ff @(posedge clk) begin
        if (!clear) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            count_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // done is a registered copy of "next state is DONE".
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (div_if.start) begin
                        if (div_if.divisor == '0) begin
                            // Saturate: quotient all ones, remainder passes the
                            // dividend through.
                            quot_q  <= '1;
                            rem_q   <= div_if.dividend;
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            a_q     <= '0;
                            q_q     <= div_if.dividend;
                            m_q     <= div_if.divisor;
                            count_q <= CW'(DATA_WIDTH);
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    a_q     <= a_d;
                    q_q     <= q_d;
                    count_q <= count_q - CW'(1);
                    // Last iteration: publish the step's output directly so
                    // results appear together with the state change.
                    if (count_q == CW'(1)) begin
                        quot_q  <= q_d;
                        rem_q   <= a_d[DATA_WIDTH-1:0];
                        dbz_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign div_if.busy        = (state_q != IDLE);
    assign div_if.done        = done_q;
    assign div_if.quotient    = quot_q;
    assign div_if.remainder   = rem_q;
    assign div_if.div_by_zero = dbz_q;
    assign state_o            = state_q;

endmodule : restoring_divider
